com_fifo_fwft_rd: RTL

COM_FIFO_FWFT_RD -- requirements
Module: com_fifo_fwft_rd

---
 rtl/com_fifo_fwft_rd.sv | 114 +++++++++++
 1 files changed

// File: rtl/com_fifo_fwft_rd.sv
// First-word-fall-through read adapter for a sync FIFO controller driving a
// 1-cycle-latency RAM. A 3-entry skid buffer absorbs the RAM latency so the
// output stream can sustain one word per cycle, and fifo_rd_en never depends
// combinationally on m_ready.
//
// Optional build macro: COM_FIFO_FWFT_LEVEL_EN adds the buf_level output
// (occupancy plus the word in flight from the RAM).
module com_fifo_fwft_rd #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rdata,
    output logic          m_valid,
    input  logic          m_ready,
`ifdef COM_FIFO_FWFT_LEVEL_EN
    output logic [DW-1:0] m_data,
    output logic [1:0]    buf_level
`else
    output logic [DW-1:0] m_data
`endif
);

    localparam int unsigned Entries = 3;

    logic [DW-1:0] mem_q [Entries];
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          infl_q, infl_d;

    logic [2:0]    occ_sum;
    logic          push;
    logic          pop;

    // Pointers step 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue/accept decisions come from registered state only.
    always_comb begin
        occ_sum    = {1'b0, occ_q} + {2'b00, infl_q};
        // Reserve a slot for the word already in flight so the buffer never overflows.
        fifo_rd_en = !fifo_empty && !clear && (occ_sum < 3'd3);
        push       = infl_q && !clear;
        m_valid    = (occ_q != 2'd0);
        pop        = m_valid && m_ready && !clear;
        m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
    end

    // Next-state for pointers, occupancy and the in-flight flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        infl_d   = fifo_rd_en;
        if (clear) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            occ_d    = 2'd0;
            infl_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state; reset drops any word still in flight from the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
        end
    end

    // Buffer storage; RAM data is captured the cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Entries); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= fifo_rdata;
        end
    end

`ifdef COM_FIFO_FWFT_LEVEL_EN
    // Occupancy plus in-flight word; bounded to 3 by the issue rule.
    always_comb begin
        buf_level = occ_sum[1:0];
    end
`endif

endmodule
